// File: rtl/tone_voice_pkg.sv
// Shared types and constants for the tone voice: envelope state encoding and envelope limits.
package tone_voice_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam logic [7:0] ENV_MAX     = 8'hFF;
    localparam int         FRAME_W_DEF = 8;
    localparam int         DIV_W_DEF   = 16;
endpackage

// File: rtl/tone_voice_if.sv
// Control/status bundle between a voice controller (master) and the tone voice (slave).
interface tone_voice_if #(parameter int DIV_W = 16);
    import tone_voice_pkg::*;

    logic             note_on;
    logic [DIV_W-1:0] freq_div;
    logic [7:0]       attack_rate;
    logic [7:0]       decay_rate;
    logic [7:0]       sustain_level;
    logic [7:0]       sample;
    logic             frame_tick;
    env_state_t       env_state;

    modport master (
        output note_on, freq_div, attack_rate, decay_rate, sustain_level,
        input  sample, frame_tick, env_state
    );

    modport slave (
        input  note_on, freq_div, attack_rate, decay_rate, sustain_level,
        output sample, frame_tick, env_state
    );
endinterface

// File: rtl/tone_voice_osc.sv
// Square-wave oscillator: toggles every freq_div clocks; a zero divider parks it low.
module tone_voice_osc #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] i_freq_div,
    output logic             o_square
);
    logic [DIV_W-1:0] r_phase;
    logic             r_square;

    // The >= compare makes a shrinking divider reload immediately instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= '0;
            r_square <= 1'b0;
        end else if (i_freq_div == '0) begin
            r_phase  <= '0;
            r_square <= 1'b0;
        end else if (r_phase >= i_freq_div - DIV_W'(1)) begin
            r_phase  <= '0;
            r_square <= ~r_square;
        end else begin
            r_phase <= r_phase + DIV_W'(1);
        end
    end

    assign o_square = r_square;
endmodule

// File: rtl/tone_voice.sv
// Single tone voice: square oscillator gated by a linear ADSR envelope, sample refreshed once per PWM frame.
module tone_voice
    import tone_voice_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    tone_voice_if.slave  bus
);
    localparam logic [FRAME_W-1:0] FRAME_PRE = {{(FRAME_W-1){1'b1}}, 1'b0};

    function automatic logic [7:0] env_inc(input logic [7:0] e);
        return (e == ENV_MAX) ? ENV_MAX : e + 8'd1;
    endfunction

    function automatic logic [7:0] env_dec(input logic [7:0] e);
        return (e == 8'd0) ? 8'd0 : e - 8'd1;
    endfunction

    env_state_t         r_state, w_state_nx;
    logic [7:0]         r_env, w_env_nx;
    logic [7:0]         r_rate_cnt, w_rate_nx;
    logic [7:0]         r_sample;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_frame_tick;
    logic               w_square;
    logic [7:0]         w_env_inc, w_env_dec;
    logic               w_step_atk, w_step_dec;

    tone_voice_osc #(.DIV_W(DIV_W)) u_osc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_freq_div (bus.freq_div),
        .o_square   (w_square)
    );

    // Tick is registered one count early so it is high exactly while frame_cnt is at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_cnt  <= r_frame_cnt + FRAME_W'(1);
            r_frame_tick <= (r_frame_cnt == FRAME_PRE);
        end
    end

    assign w_env_inc  = env_inc(r_env);
    assign w_env_dec  = env_dec(r_env);
    assign w_step_atk = (r_rate_cnt >= bus.attack_rate);
    assign w_step_dec = (r_rate_cnt >= bus.decay_rate);

    // Gate-driven transitions take priority over envelope steps within the same tick.
    always_comb begin
        w_state_nx = r_state;
        w_env_nx   = r_env;
        w_rate_nx  = r_rate_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.note_on) begin
                    w_state_nx = ST_ATTACK;
                    w_rate_nx  = 8'd0;
                end
            end
            ST_ATTACK: begin
                if (!bus.note_on) begin
                    w_state_nx = ST_RELEASE;
                    w_rate_nx  = 8'd0;
                end else if (r_env == ENV_MAX) begin
                    w_state_nx = ST_DECAY;
                    w_rate_nx  = 8'd0;
                end else if (w_step_atk) begin
                    w_rate_nx = 8'd0;
                    w_env_nx  = w_env_inc;
                    if (w_env_inc == ENV_MAX) w_state_nx = ST_DECAY;
                end else begin
                    w_rate_nx = r_rate_cnt + 8'd1;
                end
            end
            ST_DECAY: begin
                if (!bus.note_on) begin
                    w_state_nx = ST_RELEASE;
                    w_rate_nx  = 8'd0;
                end else if (w_step_dec) begin
                    w_rate_nx = 8'd0;
                    if (w_env_dec <= bus.sustain_level) begin
                        w_env_nx   = bus.sustain_level;
                        w_state_nx = ST_SUSTAIN;
                    end else begin
                        w_env_nx = w_env_dec;
                    end
                end else begin
                    w_rate_nx = r_rate_cnt + 8'd1;
                end
            end
            ST_SUSTAIN: begin
                if (!bus.note_on) begin
                    w_state_nx = ST_RELEASE;
                    w_rate_nx  = 8'd0;
                end else if (bus.sustain_level < r_env) begin
                    w_env_nx = bus.sustain_level;
                end
            end
            ST_RELEASE: begin
                if (bus.note_on) begin
                    w_state_nx = ST_ATTACK;
                    w_rate_nx  = 8'd0;
                end else if (r_env == 8'd0) begin
                    w_state_nx = ST_IDLE;
                end else if (w_step_dec) begin
                    w_rate_nx = 8'd0;
                    w_env_nx  = w_env_dec;
                    if (w_env_dec == 8'd0) w_state_nx = ST_IDLE;
                end else begin
                    w_rate_nx = r_rate_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_rate_nx  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_env      <= 8'd0;
            r_rate_cnt <= 8'd0;
            r_sample   <= 8'd0;
        end else if (r_frame_tick) begin
            r_state    <= w_state_nx;
            r_env      <= w_env_nx;
            r_rate_cnt <= w_rate_nx;
            r_sample   <= (w_square && (bus.freq_div != '0)) ? w_env_nx : 8'd0;
        end
    end

    assign bus.sample     = r_sample;
    assign bus.frame_tick = r_frame_tick;
    assign bus.env_state  = r_state;
endmodule
